// File: rtl/siso_ctrl_pkg.sv
// Shared definitions for the SISO shift-chain controller: state encoding and
// counter sizing.
package siso_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    STATE_IDLE = ST_IDLE,
    STATE_RUN  = ST_RUN,
    STATE_DONE = ST_DONE
  } state_t;

  // Counter must hold 0..data_width+pipe_depth without wrapping.
  function automatic int cnt_width(input int data_width, input int pipe_depth);
    return $clog2(data_width + pipe_depth + 1);
  endfunction

endpackage

// File: rtl/serial_in_serial_out_register.sv
// Plain serial-in/serial-out shift chain: data_in appears on data_out
// exactly DEPTH clock cycles later.
module serial_in_serial_out_register #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  output logic data_out
);

  logic [DEPTH:0] stage;

  assign stage[0] = data_in;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      always_ff @(posedge clk) begin
        if (rst) begin
          stage[gi+1] <= 1'b0;
        end else begin
          stage[gi+1] <= stage[gi];
        end
      end
    end
  endgenerate

  assign data_out = stage[DEPTH];

endmodule

// File: rtl/siso_shift_controller.sv
// Serialises one word LSB-first into an external SISO chain of known latency,
// reassembles the returning bits and flags any difference from what was sent.
module siso_shift_controller
  import siso_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int PIPE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  sr_data_in,
  input  logic                  sr_data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_err,
  output logic                  busy
);

  localparam int CW = cnt_width(DATA_WIDTH, PIPE_DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH + PIPE_DEPTH - 1);
  localparam logic [CW-1:0] CNT_CAP  = CW'(PIPE_DEPTH);

  state_t                  state_reg, state_next;
  logic                    accept, run_last;
  logic [CW-1:0]           cnt_reg;
  logic [DATA_WIDTH-1:0]   tx_word_reg, tx_shift_reg, rx_reg;
  logic [DATA_WIDTH-1:0]   rx_shifted;
  logic [DATA_WIDTH:0]     rx_cat;
  logic                    sr_bit_reg;
  logic [DATA_WIDTH-1:0]   m_data_reg;
  logic                    m_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= STATE_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    run_last   = 1'b0;
    case (state_reg)
      STATE_IDLE: begin
        if (s_valid) begin
          accept     = 1'b1;
          state_next = STATE_RUN;
        end
      end
      STATE_RUN: begin
        if (cnt_reg == CNT_LAST) begin
          run_last   = 1'b1;
          state_next = STATE_DONE;
        end
      end
      STATE_DONE: begin
        if (m_ready) begin
          state_next = STATE_IDLE;
        end
      end
      default: state_next = STATE_IDLE;
    endcase
  end

  // Returning bit enters at the MSB so the first bit sent ends up in bit 0.
  assign rx_cat     = {sr_data_out, rx_reg};
  assign rx_shifted = rx_cat[DATA_WIDTH:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      tx_word_reg  <= '0;
      tx_shift_reg <= '0;
      rx_reg       <= '0;
      sr_bit_reg   <= 1'b0;
      m_data_reg   <= '0;
      m_err_reg    <= 1'b0;
    end else if (accept) begin
      cnt_reg      <= '0;
      tx_word_reg  <= s_data;
      tx_shift_reg <= s_data >> 1;
      rx_reg       <= '0;
      sr_bit_reg   <= s_data[0];
    end else if (state_reg == STATE_RUN) begin
      cnt_reg      <= cnt_reg + CW'(1);
      tx_shift_reg <= tx_shift_reg >> 1;
      // Shift register drains to zero, so the line idles low after the last bit.
      sr_bit_reg   <= run_last ? 1'b0 : tx_shift_reg[0];
      if (cnt_reg >= CNT_CAP) begin
        rx_reg <= rx_shifted;
      end
      if (run_last) begin
        m_data_reg <= rx_shifted;
        m_err_reg  <= (rx_shifted != tx_word_reg);
      end
    end
  end

  assign s_ready    = (state_reg == STATE_IDLE);
  assign busy       = (state_reg != STATE_IDLE);
  assign m_valid    = (state_reg == STATE_DONE);
  assign sr_data_in = sr_bit_reg;
  assign m_data     = m_data_reg;
  assign m_err      = m_err_reg;

endmodule

// File: tb/tb_siso_shift_controller.sv
// Loopback bench: controller driving a SISO chain of matching depth, with an
// optional stuck-at-0 fault injected on the chain output.
module tb_siso_shift_controller;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         sr_data_in;
  logic         sr_data_out;
  logic         chain_out;
  logic         stuck;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         m_err;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  siso_shift_controller #(.DATA_WIDTH(W), .PIPE_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sr_data_in(sr_data_in), .sr_data_out(sr_data_out),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_err(m_err), .busy(busy)
  );

  serial_in_serial_out_register #(.DEPTH(D)) chain (
    .clk(clk), .rst(rst), .data_in(sr_data_in), .data_out(chain_out)
  );

  assign sr_data_out = stuck ? 1'b0 : chain_out;

  typedef struct {
    logic [W-1:0] data;
    logic         stuck;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full transfer with m_ready high: checks serial bit stream, latency and result.
  task automatic do_transfer(input logic [W-1:0] data, input logic [W-1:0] exp_data,
                             input logic exp_err);
    int n;
    n = 0;
    m_ready = 1'b1;
    while (!s_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_xfer", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = data;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < W + D; k++) begin
      check("sr_data_in", sr_data_in, (k < W) ? data[k] : 1'b0);
      if (k == W + D - 1) check("m_valid_early", m_valid, 1'b0);
      tick();
    end
    check("m_valid_latency", m_valid, 1'b1);
    check("m_data", m_data, exp_data);
    check("m_err", m_err, exp_err);
    $display("xfer data=%h m_data=%h m_err=%b", data, m_data, m_err);
    tick();
    check("m_valid_drop", m_valid, 1'b0);
    check("s_ready_after", s_ready, 1'b1);
  endtask

  initial begin
    int  n;
    bit  seen;

    vecs[0] = '{4'hB, 1'b0, 4'hB, 1'b0};
    vecs[1] = '{4'h0, 1'b0, 4'h0, 1'b0};
    vecs[2] = '{4'hF, 1'b0, 4'hF, 1'b0};
    vecs[3] = '{4'h1, 1'b0, 4'h1, 1'b0};
    vecs[4] = '{4'h8, 1'b0, 4'h8, 1'b0};
    vecs[5] = '{4'hB, 1'b1, 4'h0, 1'b1};
    vecs[6] = '{4'h0, 1'b1, 4'h0, 1'b0};
    vecs[7] = '{4'h7, 1'b1, 4'h0, 1'b1};

    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; stuck = 1'b0;
    tick();
    tick();
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_sr_data_in", sr_data_in, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_m_data", m_data, 4'h0);
    check("rst_m_err", m_err, 1'b0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      stuck = vecs[i].stuck;
      do_transfer(vecs[i].data, vecs[i].exp_data, vecs[i].exp_err);
    end
    stuck = 1'b0;

    // Consumer stall with a competing word offered during DONE.
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 4'h3;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < W + D; k++) tick();
    check("stall_m_valid", m_valid, 1'b1);
    s_valid = 1'b1;
    s_data  = 4'hC;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_m_valid_hold", m_valid, 1'b1);
      check("stall_m_data_hold", m_data, 4'h3);
      check("stall_m_err_hold", m_err, 1'b0);
      check("stall_s_ready", s_ready, 1'b0);
    end
    $display("xfer data=3 stalled m_data=%h m_err=%b", m_data, m_err);
    m_ready = 1'b1;
    tick();
    check("stall_release_idle", s_ready, 1'b1);
    check("stall_release_m_valid", m_valid, 1'b0);
    tick();
    s_valid = 1'b0;
    check("stall_second_busy", busy, 1'b1);
    for (int k = 0; k < W + D - 1; k++) tick();
    check("stall_second_early", m_valid, 1'b0);
    tick();
    check("stall_second_valid", m_valid, 1'b1);
    check("stall_second_data", m_data, 4'hC);
    check("stall_second_err", m_err, 1'b0);
    $display("xfer data=c m_data=%h m_err=%b", m_data, m_err);
    tick();

    // Reset in RUN cycle 2, then a clean transfer.
    s_valid = 1'b1;
    s_data  = 4'h9;
    tick();
    s_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_s_ready", s_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_sr_data_in", sr_data_in, 1'b0);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_data", m_data, 4'h0);
    $display("xfer data=9 aborted by reset");
    do_transfer(4'h6, 4'h6, 1'b0);

    // Back-to-back words with s_valid held high.
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 4'h5;
    tick();
    s_data = 4'hA;
    n = 0;
    seen = 1'b0;
    while (!s_ready && n < 40) begin
      if (m_valid) begin
        seen = 1'b1;
        check("b2b_first_data", m_data, 4'h5);
        check("b2b_first_err", m_err, 1'b0);
        $display("xfer data=5 m_data=%h m_err=%b", m_data, m_err);
      end
      tick();
      n++;
    end
    check("b2b_first_seen", seen, 1'b1);
    check("b2b_spacing", n + 1, W + D + 2);
    tick();
    s_valid = 1'b0;
    n = 0;
    while (!m_valid && n < 40) begin
      tick();
      n++;
    end
    check("b2b_second_latency", n, W + D);
    check("b2b_second_data", m_data, 4'hA);
    check("b2b_second_err", m_err, 1'b0);
    $display("xfer data=a m_data=%h m_err=%b", m_data, m_err);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
